riscv_mem_lsu_axil: RTL and testbench
=====================================

Name: riscv_mem_lsu_axil

Overview:
Load/store unit and AXI-Lite master. It consumes the memory-access controls produced by instruction decode: read, write, 3-bit width {unsigned, size}, address and store data. It turns each access into one AXI-Lite read or write transaction, then returns sign- or zero-extended load data to writeback. It sits between the MEM pipeline stage and the system AXI-Lite interconnect, and stalls the pipeline while a transaction is outstanding.

Parameters:
XLEN, 64, register/data width; AXI data bus width is also XLEN (8 byte lanes)
ADDR_WIDTH, 32, AXI address width; the low ADDR_WIDTH bits of i_addr are used

Ports:
i_clk  input  1  clock
i_rst  input  1  reset, synchronous, active-high
i_req  input  1  access request valid
o_req_ready  output  1  unit idle and able to accept; a request is accepted when i_req & o_req_ready
i_read  input  1  load request
i_write  input  1  store request
i_width  input  3  [2]=unsigned (load only), [1:0]=size: 0 byte, 1 half, 2 word, 3 dword
i_addr  input  XLEN  byte address (ALU result)
i_wdata  input  XLEN  store data, right-aligned
o_busy  output  1  transaction in flight; pipeline stall
o_done  output  1  one-cycle pulse: access complete
o_rdata  output  XLEN  extended load data, valid with o_done on loads, else 0
o_misaligned  output  1  with o_done: access fault, no bus activity
o_bus_err  output  1  with o_done: RRESP/BRESP != OKAY
m_axi_awaddr  output  ADDR_WIDTH  write address, aligned down to 8 bytes
m_axi_awvalid  output  1  write address valid
m_axi_awready  input  1  write address ready
m_axi_wdata  output  XLEN  write data, lane-shifted
m_axi_wstrb  output  XLEN/8  byte strobes
m_axi_wvalid  output  1  write data valid
m_axi_wready  input  1  write data ready
m_axi_bresp  input  2  write response
m_axi_bvalid  input  1  write response valid
m_axi_bready  output  1  write response ready
m_axi_araddr  output  ADDR_WIDTH  read address, aligned down to 8 bytes
m_axi_arvalid  output  1  read address valid
m_axi_arready  input  1  read address ready
m_axi_rdata  input  XLEN  read data
m_axi_rresp  input  2  read response
m_axi_rvalid  input  1  read data valid
m_axi_rready  output  1  read data ready

Behaviour:
- Reset: state IDLE. All valid/ready outputs, o_busy, o_done, o_misaligned and o_bus_err are 0; o_rdata is 0; o_req_ready is 1. Reset mid-transaction abandons it at the next edge. No o_done is produced for an abandoned transaction.
- States: IDLE, RD_ADDR, RD_DATA, WR_ADDR_DATA, WR_RESP, DONE.
- IDLE, on accept: the request is captured (offset = addr[2:0], size, unsigned flag).
  - Misaligned: half with addr[0] set, word with addr[1:0] != 0, dword with addr[2:0] != 0. The unit goes to DONE with o_misaligned=1.
  - i_read and i_write both set, or neither set: goes to DONE with o_bus_err=1.
  - In both fault cases no AXI valid is ever raised.
  - Otherwise a load goes to RD_ADDR and a store to WR_ADDR_DATA.
- o_req_ready = (state == IDLE). o_busy = (state != IDLE) && (state != DONE).
- RD_ADDR: arvalid=1 until arready, then RD_DATA.
- RD_DATA: rready=1. On rvalid, capture rdata >> (8*offset), truncate to size, then sign- or zero-extend per the unsigned flag. A dword load ignores the flag. Capture rresp, then go to DONE.
- WR_ADDR_DATA: awvalid and wvalid rise together in the first cycle. Each drops independently after its own handshake; the two handshakes may occur in the same or different cycles. When both are done, go to WR_RESP.
- Write lane placement: wdata = i_wdata << (8*offset); wstrb = ((1 << (1 << size)) - 1) << offset.
- WR_RESP: bready=1. On bvalid, capture bresp and go to DONE.
- DONE: o_done=1 for exactly one cycle, together with o_rdata, o_bus_err and o_misaligned; then IDLE. o_rdata is 0 for stores and faults.
- AXI rules:
  - Once a valid is raised it stays high and its payload stays stable until the handshake.
  - Valids are never combinationally dependent on readies.
  - araddr/awaddr = addr with bits [2:0] cleared.
  - AxPROT is not driven by this unit (tied 0 at the top level).
- Minimum latencies, with zero-wait slaves, from accept at cycle T:
  - Load: arvalid at T+1, rvalid accepted at T+2, o_done at T+3.
  - Store: aw/w handshake at T+1, bvalid at T+2, o_done at T+3.
  - Fault: o_done at T+1.
- Back-to-back requests: the next accept is possible in the cycle after o_done.

Decomposition:
- riscv_pkg gains:
  - MEM_WIDTH_BYTE/HALF/WORD/DWORD (the existing encodings)
  - AXI_RESP_OKAY = 2'b00
  - lsu_state_t enum
- One sub-module, riscv_mem_lsu_align: a combinational load extractor/extender and store lane/strobe generator, so the bench can exhaustively check it in isolation.

Test Plan:
- LW unsigned=0, addr 0x1004, rdata 0x8765_4321_0000_0000, zero-wait slave -> araddr 0x1000; o_done at T+3; o_rdata 0xFFFF_FFFF_8765_4321.
- LBU addr 0x1007, rdata 0xAB00_0000_0000_0000 -> o_rdata 0x0000_0000_0000_00AB.
- SH addr 0x2002, wdata 0x1234, awready 3 cycles late, wready immediate -> wstrb 0x0C; wdata 0x0000_0000_1234_0000; wvalid drops after 1 cycle; awvalid held to its handshake; o_done follows bvalid by 1.
- SW addr 0x2002 -> o_done at T+1 with o_misaligned=1; no AXI valid ever asserted.
- LD with rresp=2'b10 (SLVERR) -> o_done with o_bus_err=1 and o_rdata holding the bus data.
- i_rst asserted while in WR_RESP, bvalid stalled -> next cycle all valids/readies are 0, o_req_ready=1, no o_done pulse.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared encodings for the RISC-V core slice: memory access widths, AXI responses
// and the load/store unit state machine.
package riscv_pkg;

    localparam logic [1:0] MEM_WIDTH_BYTE  = 2'd0;
    localparam logic [1:0] MEM_WIDTH_HALF  = 2'd1;
    localparam logic [1:0] MEM_WIDTH_WORD  = 2'd2;
    localparam logic [1:0] MEM_WIDTH_DWORD = 2'd3;

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_DATA,
        WR_ADDR_DATA,
        WR_RESP,
        DONE
    } lsu_state_t;

endpackage

// File: rtl/riscv_mem_lsu_align.sv
// Combinational lane logic: extracts and extends load data from a bus beat, and
// places store data and byte strobes onto the correct lanes.
module riscv_mem_lsu_align
    import riscv_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [2:0]        offset,
    input  logic [1:0]        size,
    input  logic              is_unsigned,
    input  logic [XLEN-1:0]   bus_rdata,
    input  logic [XLEN-1:0]   store_data,
    output logic [XLEN-1:0]   load_data,
    output logic [XLEN-1:0]   lane_wdata,
    output logic [XLEN/8-1:0] lane_wstrb
);

    localparam int STRB = XLEN / 8;

    logic [5:0]      shamt;
    logic [XLEN-1:0] shifted;
    logic            sign_bit;
    logic [3:0]      nbytes;
    logic [3:0]      first_lane;
    logic [3:0]      end_lane;

    assign shamt   = {offset, 3'b000};
    assign shifted = bus_rdata >> shamt;

    always_comb begin
        load_data = shifted;
        sign_bit  = 1'b0;
        case (size)
            MEM_WIDTH_BYTE: begin
                sign_bit  = shifted[7] & ~is_unsigned;
                load_data = {{(XLEN-8){sign_bit}}, shifted[7:0]};
            end
            MEM_WIDTH_HALF: begin
                sign_bit  = shifted[15] & ~is_unsigned;
                load_data = {{(XLEN-16){sign_bit}}, shifted[15:0]};
            end
            MEM_WIDTH_WORD: begin
                sign_bit  = shifted[31] & ~is_unsigned;
                load_data = {{(XLEN-32){sign_bit}}, shifted[31:0]};
            end
            default: load_data = shifted;
        endcase
    end

    assign lane_wdata = store_data << shamt;

    // A lane is strobed when it falls inside [offset, offset + bytes).
    assign nbytes     = 4'd1 << size;
    assign first_lane = {1'b0, offset};
    assign end_lane   = first_lane + nbytes;

    generate
        for (genvar gi = 0; gi < STRB; gi++) begin : g_strb
            assign lane_wstrb[gi] = (4'(gi) >= first_lane) && (4'(gi) < end_lane);
        end
    endgenerate

endmodule

// File: rtl/riscv_mem_lsu_axil.sv
// Load/store unit: turns one MEM-stage access into a single AXI-Lite read or write
// and returns extended load data with a one-cycle completion pulse.
module riscv_mem_lsu_axil
    import riscv_pkg::*;
#(
    parameter int XLEN       = 64,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_req,
    output logic                  o_req_ready,
    input  logic                  i_read,
    input  logic                  i_write,
    input  logic [2:0]            i_width,
    input  logic [XLEN-1:0]       i_addr,
    input  logic [XLEN-1:0]       i_wdata,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [XLEN-1:0]       o_rdata,
    output logic                  o_misaligned,
    output logic                  o_bus_err,
    output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
    output logic                  m_axi_awvalid,
    input  logic                  m_axi_awready,
    output logic [XLEN-1:0]       m_axi_wdata,
    output logic [XLEN/8-1:0]     m_axi_wstrb,
    output logic                  m_axi_wvalid,
    input  logic                  m_axi_wready,
    input  logic [1:0]            m_axi_bresp,
    input  logic                  m_axi_bvalid,
    output logic                  m_axi_bready,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    input  logic [XLEN-1:0]       m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready
);

    lsu_state_t state_reg, state_next;

    logic [ADDR_WIDTH-1:0] addr_reg;
    logic [2:0]            offset_reg;
    logic [1:0]            size_reg;
    logic                  uns_reg;
    logic [XLEN-1:0]       store_data_reg;
    logic [XLEN-1:0]       rdata_reg;
    logic                  bus_err_reg;
    logic                  misaligned_reg;
    logic                  aw_done_reg;
    logic                  w_done_reg;

    logic                  kind_fault;
    logic                  align_fault;
    logic [XLEN-1:0]       load_data;
    logic                  unused_addr_bits;

    assign unused_addr_bits = ^i_addr[XLEN-1:ADDR_WIDTH];

    assign kind_fault = (i_read == i_write);

    always_comb begin
        align_fault = 1'b0;
        case (i_width[1:0])
            MEM_WIDTH_HALF:  align_fault = i_addr[0];
            MEM_WIDTH_WORD:  align_fault = |i_addr[1:0];
            MEM_WIDTH_DWORD: align_fault = |i_addr[2:0];
            default:         align_fault = 1'b0;
        endcase
    end

    riscv_mem_lsu_align #(
        .XLEN(XLEN)
    ) u_align (
        .offset      (offset_reg),
        .size        (size_reg),
        .is_unsigned (uns_reg),
        .bus_rdata   (m_axi_rdata),
        .store_data  (store_data_reg),
        .load_data   (load_data),
        .lane_wdata  (m_axi_wdata),
        .lane_wstrb  (m_axi_wstrb)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg      <= IDLE;
            addr_reg       <= '0;
            offset_reg     <= '0;
            size_reg       <= '0;
            uns_reg        <= 1'b0;
            store_data_reg <= '0;
            rdata_reg      <= '0;
            bus_err_reg    <= 1'b0;
            misaligned_reg <= 1'b0;
            aw_done_reg    <= 1'b0;
            w_done_reg     <= 1'b0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    if (i_req) begin
                        addr_reg       <= {i_addr[ADDR_WIDTH-1:3], 3'b000};
                        offset_reg     <= i_addr[2:0];
                        size_reg       <= i_width[1:0];
                        uns_reg        <= i_width[2];
                        store_data_reg <= i_wdata;
                        rdata_reg      <= '0;
                        aw_done_reg    <= 1'b0;
                        w_done_reg     <= 1'b0;
                        // An ill-formed read/write pair is reported as a bus error
                        // before alignment is even considered.
                        bus_err_reg    <= kind_fault;
                        misaligned_reg <= ~kind_fault & align_fault;
                    end
                end
                RD_DATA: begin
                    if (m_axi_rvalid) begin
                        rdata_reg   <= load_data;
                        bus_err_reg <= (m_axi_rresp != AXI_RESP_OKAY);
                    end
                end
                WR_ADDR_DATA: begin
                    if (m_axi_awvalid && m_axi_awready) aw_done_reg <= 1'b1;
                    if (m_axi_wvalid && m_axi_wready)   w_done_reg  <= 1'b1;
                end
                WR_RESP: begin
                    if (m_axi_bvalid) bus_err_reg <= (m_axi_bresp != AXI_RESP_OKAY);
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next    = state_reg;
        o_req_ready   = 1'b0;
        o_busy        = 1'b0;
        o_done        = 1'b0;
        m_axi_arvalid = 1'b0;
        m_axi_rready  = 1'b0;
        m_axi_awvalid = 1'b0;
        m_axi_wvalid  = 1'b0;
        m_axi_bready  = 1'b0;
        case (state_reg)
            IDLE: begin
                o_req_ready = 1'b1;
                if (i_req) begin
                    if (kind_fault || align_fault) state_next = DONE;
                    else if (i_read)               state_next = RD_ADDR;
                    else                           state_next = WR_ADDR_DATA;
                end
            end
            RD_ADDR: begin
                o_busy        = 1'b1;
                m_axi_arvalid = 1'b1;
                if (m_axi_arready) state_next = RD_DATA;
            end
            RD_DATA: begin
                o_busy       = 1'b1;
                m_axi_rready = 1'b1;
                if (m_axi_rvalid) state_next = DONE;
            end
            WR_ADDR_DATA: begin
                o_busy        = 1'b1;
                m_axi_awvalid = ~aw_done_reg;
                m_axi_wvalid  = ~w_done_reg;
                // Leave once each channel has handshaked, now or in an earlier cycle.
                if ((aw_done_reg || m_axi_awready) && (w_done_reg || m_axi_wready))
                    state_next = WR_RESP;
            end
            WR_RESP: begin
                o_busy       = 1'b1;
                m_axi_bready = 1'b1;
                if (m_axi_bvalid) state_next = DONE;
            end
            DONE: begin
                o_done     = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign m_axi_araddr = addr_reg;
    assign m_axi_awaddr = addr_reg;
    assign o_rdata      = o_done ? rdata_reg : '0;
    assign o_bus_err    = o_done & bus_err_reg;
    assign o_misaligned = o_done & misaligned_reg;

endmodule

// File: tb/tb_riscv_mem_lsu_axil.sv
// Directed bench for the load/store unit with a scripted AXI-Lite slave.
module tb_riscv_mem_lsu_axil;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_req;
    logic        o_req_ready;
    logic        i_read;
    logic        i_write;
    logic [2:0]  i_width;
    logic [63:0] i_addr;
    logic [63:0] i_wdata;
    logic        o_busy;
    logic        o_done;
    logic [63:0] o_rdata;
    logic        o_misaligned;
    logic        o_bus_err;
    logic [31:0] m_axi_awaddr;
    logic        m_axi_awvalid;
    logic        m_axi_awready;
    logic [63:0] m_axi_wdata;
    logic [7:0]  m_axi_wstrb;
    logic        m_axi_wvalid;
    logic        m_axi_wready;
    logic [1:0]  m_axi_bresp;
    logic        m_axi_bvalid;
    logic        m_axi_bready;
    logic [31:0] m_axi_araddr;
    logic        m_axi_arvalid;
    logic        m_axi_arready;
    logic [63:0] m_axi_rdata;
    logic [1:0]  m_axi_rresp;
    logic        m_axi_rvalid;
    logic        m_axi_rready;

    int n_cmp = 0;
    int n_bad = 0;

    // Observations recorded by run_access for the calling test.
    int          r_done_lat;
    int          r_b_to_done;
    int          r_ar_cnt;
    int          r_aw_cnt;
    int          r_w_cnt;
    logic [31:0] r_araddr;
    logic [31:0] r_awaddr;
    logic [63:0] r_wdata;
    logic [7:0]  r_wstrb;
    logic [63:0] r_rdata;
    logic        r_err;
    logic        r_mis;
    logic        r_any_valid;
    logic        r_unstable;
    logic        r_ready_at_req;
    logic        r_done_at_req;

    always #5 i_clk = ~i_clk;

    riscv_mem_lsu_axil #(.XLEN(64), .ADDR_WIDTH(32)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_req(i_req), .o_req_ready(o_req_ready),
        .i_read(i_read), .i_write(i_write), .i_width(i_width), .i_addr(i_addr),
        .i_wdata(i_wdata), .o_busy(o_busy), .o_done(o_done), .o_rdata(o_rdata),
        .o_misaligned(o_misaligned), .o_bus_err(o_bus_err),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
        .m_axi_wready(m_axi_wready), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
        .m_axi_bready(m_axi_bready), .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid),
        .m_axi_arready(m_axi_arready), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
    );

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, required finish before 500us");
        $fatal(1);
    end

    // Issues one request and plays the slave: arready/wready always high, awready
    // after aw_delay cycles of awvalid, rvalid/bvalid one cycle after their address phase.
    task automatic run_access(input logic rd, input logic wr, input logic [2:0] w,
                              input logic [63:0] a, input logic [63:0] d, input logic [63:0] bus,
                              input logic [1:0] rresp, input logic [1:0] bresp, input int aw_delay);
        bit ar_hs = 0, r_hs = 0, aw_hs = 0, w_hs = 0, b_hs = 0;
        int b_cyc = -1;
        r_done_lat = -1; r_b_to_done = -1; r_ar_cnt = 0; r_aw_cnt = 0; r_w_cnt = 0;
        r_araddr = '0; r_awaddr = '0; r_wdata = '0; r_wstrb = '0; r_rdata = 'x;
        r_err = 1'bx; r_mis = 1'bx; r_any_valid = 0; r_unstable = 0;
        @(negedge i_clk);
        r_ready_at_req = o_req_ready;
        r_done_at_req  = o_done;
        i_req = 1; i_read = rd; i_write = wr; i_width = w; i_addr = a; i_wdata = d;
        m_axi_arready = 1; m_axi_wready = 1; m_axi_awready = 0;
        m_axi_rdata = bus; m_axi_rresp = rresp; m_axi_bresp = bresp;
        m_axi_rvalid = 0; m_axi_bvalid = 0;
        for (int cyc = 1; cyc <= 30; cyc++) begin
            @(negedge i_clk);
            i_req = 0;
            if (o_done) begin
                r_done_lat = cyc; r_rdata = o_rdata; r_err = o_bus_err; r_mis = o_misaligned;
                if (b_cyc > 0) r_b_to_done = cyc - b_cyc;
                break;
            end
            m_axi_rvalid = ar_hs && !r_hs;
            m_axi_bvalid = aw_hs && w_hs && !b_hs;
            if (m_axi_arvalid || m_axi_awvalid || m_axi_wvalid) r_any_valid = 1;
            if (m_axi_arvalid) begin
                r_ar_cnt++; r_araddr = m_axi_araddr;
                if (m_axi_arready) ar_hs = 1;
            end
            if (m_axi_awvalid) begin
                if (r_aw_cnt > 0 && m_axi_awaddr !== r_awaddr) r_unstable = 1;
                r_awaddr = m_axi_awaddr;
                m_axi_awready = (r_aw_cnt >= aw_delay);
                r_aw_cnt++;
                if (m_axi_awready) aw_hs = 1;
            end else begin
                m_axi_awready = 0;
            end
            if (m_axi_wvalid) begin
                if (r_w_cnt > 0 && (m_axi_wdata !== r_wdata || m_axi_wstrb !== r_wstrb)) r_unstable = 1;
                r_wdata = m_axi_wdata; r_wstrb = m_axi_wstrb; r_w_cnt++;
                w_hs = 1;
            end
            if (m_axi_rvalid && m_axi_rready) r_hs = 1;
            if (m_axi_bvalid && m_axi_bready) begin b_hs = 1; b_cyc = cyc; end
        end
        m_axi_rvalid = 0; m_axi_bvalid = 0; m_axi_awready = 0;
    endtask

    task automatic test_reset();
        i_rst = 1; i_req = 0; i_read = 0; i_write = 0; i_width = 0; i_addr = 0; i_wdata = 0;
        m_axi_awready = 0; m_axi_wready = 0; m_axi_bresp = 0; m_axi_bvalid = 0;
        m_axi_arready = 0; m_axi_rdata = 0; m_axi_rresp = 0; m_axi_rvalid = 0;
        repeat (3) @(negedge i_clk);
        i_rst = 0;
        @(negedge i_clk);
        n_cmp++; if (o_req_ready !== 1'b1) begin n_bad++; $display("FAIL reset_req_ready: got %b want 1", o_req_ready); end
        n_cmp++; if (o_busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", o_busy); end
        n_cmp++; if (o_done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", o_done); end
        n_cmp++; if (o_rdata !== 64'h0) begin n_bad++; $display("FAIL reset_rdata: got %h want 0", o_rdata); end
        n_cmp++; if ({o_misaligned, o_bus_err} !== 2'b00) begin n_bad++; $display("FAIL reset_flags: got %b want 00", {o_misaligned, o_bus_err}); end
        n_cmp++; if ({m_axi_arvalid, m_axi_rready, m_axi_awvalid, m_axi_wvalid, m_axi_bready} !== 5'b0) begin
            n_bad++; $display("FAIL reset_axi: got %b want 00000", {m_axi_arvalid, m_axi_rready, m_axi_awvalid, m_axi_wvalid, m_axi_bready});
        end
        $display("reset: ready=%b busy=%b", o_req_ready, o_busy);
    endtask

    task automatic test_load_word();
        run_access(1, 0, 3'b010, 64'h1004, 64'h0, 64'h8765_4321_0000_0000, 2'b00, 2'b00, 0);
        $display("LW 0x1004: araddr=%h lat=%0d rdata=%h", r_araddr, r_done_lat, r_rdata);
        n_cmp++; if (r_araddr !== 32'h1000) begin n_bad++; $display("FAIL lw_araddr: got %h want 00001000", r_araddr); end
        n_cmp++; if (r_done_lat !== 3) begin n_bad++; $display("FAIL lw_latency: got %0d want 3", r_done_lat); end
        n_cmp++; if (r_rdata !== 64'hFFFF_FFFF_8765_4321) begin n_bad++; $display("FAIL lw_rdata: got %h want ffffffff87654321", r_rdata); end
        n_cmp++; if ({r_err, r_mis} !== 2'b00) begin n_bad++; $display("FAIL lw_flags: got %b want 00", {r_err, r_mis}); end
        n_cmp++; if (r_ar_cnt !== 1) begin n_bad++; $display("FAIL lw_ar_cycles: got %0d want 1", r_ar_cnt); end
    endtask

    task automatic test_load_narrow();
        run_access(1, 0, 3'b100, 64'h1007, 64'h0, 64'hAB00_0000_0000_0000, 2'b00, 2'b00, 0);
        $display("LBU 0x1007: rdata=%h", r_rdata);
        n_cmp++; if (r_rdata !== 64'h0000_0000_0000_00AB) begin n_bad++; $display("FAIL lbu_rdata: got %h want 00000000000000ab", r_rdata); end
        n_cmp++; if (r_araddr !== 32'h1000) begin n_bad++; $display("FAIL lbu_araddr: got %h want 00001000", r_araddr); end
        run_access(1, 0, 3'b001, 64'h1006, 64'h0, 64'h8001_0000_0000_0000, 2'b00, 2'b00, 0);
        $display("LH 0x1006: rdata=%h", r_rdata);
        n_cmp++; if (r_rdata !== 64'hFFFF_FFFF_FFFF_8001) begin n_bad++; $display("FAIL lh_rdata: got %h want ffffffffffff8001", r_rdata); end
        run_access(1, 0, 3'b000, 64'h1003, 64'h0, 64'h0000_0000_8000_0000, 2'b00, 2'b00, 0);
        $display("LB 0x1003: rdata=%h", r_rdata);
        n_cmp++; if (r_rdata !== 64'hFFFF_FFFF_FFFF_FF80) begin n_bad++; $display("FAIL lb_rdata: got %h want ffffffffffffff80", r_rdata); end
        run_access(1, 0, 3'b110, 64'h1004, 64'h0, 64'h8765_4321_0000_0000, 2'b00, 2'b00, 0);
        $display("LWU 0x1004: rdata=%h", r_rdata);
        n_cmp++; if (r_rdata !== 64'h0000_0000_8765_4321) begin n_bad++; $display("FAIL lwu_rdata: got %h want 0000000087654321", r_rdata); end
        run_access(1, 0, 3'b111, 64'h1008, 64'h0, 64'h8000_0000_0000_0001, 2'b00, 2'b00, 0);
        $display("LD(u) 0x1008: araddr=%h rdata=%h", r_araddr, r_rdata);
        n_cmp++; if (r_rdata !== 64'h8000_0000_0000_0001) begin n_bad++; $display("FAIL ld_rdata: got %h want 8000000000000001", r_rdata); end
        n_cmp++; if (r_araddr !== 32'h1008) begin n_bad++; $display("FAIL ld_araddr: got %h want 00001008", r_araddr); end
    endtask

    task automatic test_load_slverr();
        run_access(1, 0, 3'b011, 64'h3000, 64'h0, 64'hDEAD_BEEF_0123_4567, 2'b10, 2'b00, 0);
        $display("LD SLVERR: err=%b rdata=%h", r_err, r_rdata);
        n_cmp++; if (r_err !== 1'b1) begin n_bad++; $display("FAIL ld_slverr_err: got %b want 1", r_err); end
        n_cmp++; if (r_rdata !== 64'hDEAD_BEEF_0123_4567) begin n_bad++; $display("FAIL ld_slverr_rdata: got %h want deadbeef01234567", r_rdata); end
        n_cmp++; if (r_mis !== 1'b0) begin n_bad++; $display("FAIL ld_slverr_mis: got %b want 0", r_mis); end
    endtask

    task automatic test_store_half_late_aw();
        run_access(0, 1, 3'b001, 64'h2002, 64'h1234, 64'h0, 2'b00, 2'b00, 3);
        $display("SH 0x2002: awaddr=%h wstrb=%h wdata=%h aw_cyc=%0d w_cyc=%0d b2done=%0d",
                 r_awaddr, r_wstrb, r_wdata, r_aw_cnt, r_w_cnt, r_b_to_done);
        n_cmp++; if (r_wstrb !== 8'h0C) begin n_bad++; $display("FAIL sh_wstrb: got %h want 0c", r_wstrb); end
        n_cmp++; if (r_wdata !== 64'h0000_0000_1234_0000) begin n_bad++; $display("FAIL sh_wdata: got %h want 0000000012340000", r_wdata); end
        n_cmp++; if (r_awaddr !== 32'h2000) begin n_bad++; $display("FAIL sh_awaddr: got %h want 00002000", r_awaddr); end
        n_cmp++; if (r_w_cnt !== 1) begin n_bad++; $display("FAIL sh_wvalid_cycles: got %0d want 1", r_w_cnt); end
        n_cmp++; if (r_aw_cnt !== 4) begin n_bad++; $display("FAIL sh_awvalid_cycles: got %0d want 4", r_aw_cnt); end
        n_cmp++; if (r_b_to_done !== 1) begin n_bad++; $display("FAIL sh_b_to_done: got %0d want 1", r_b_to_done); end
        n_cmp++; if (r_unstable !== 1'b0) begin n_bad++; $display("FAIL sh_payload_stable: got %b want 0", r_unstable); end
        n_cmp++; if ({r_err, r_mis, r_rdata} !== {2'b00, 64'h0}) begin n_bad++; $display("FAIL sh_result: got err=%b mis=%b rdata=%h want 0 0 0", r_err, r_mis, r_rdata); end
    endtask

    task automatic test_store_lanes();
        run_access(0, 1, 3'b000, 64'h2005, 64'hA5, 64'h0, 2'b00, 2'b00, 0);
        $display("SB 0x2005: lat=%0d wstrb=%h wdata=%h", r_done_lat, r_wstrb, r_wdata);
        n_cmp++; if (r_done_lat !== 3) begin n_bad++; $display("FAIL sb_latency: got %0d want 3", r_done_lat); end
        n_cmp++; if (r_wstrb !== 8'h20) begin n_bad++; $display("FAIL sb_wstrb: got %h want 20", r_wstrb); end
        n_cmp++; if (r_wdata !== 64'h0000_A500_0000_0000) begin n_bad++; $display("FAIL sb_wdata: got %h want 0000a50000000000", r_wdata); end
        run_access(0, 1, 3'b010, 64'h200C, 64'hCAFE_BABE, 64'h0, 2'b00, 2'b00, 0);
        $display("SW 0x200C: awaddr=%h wstrb=%h wdata=%h", r_awaddr, r_wstrb, r_wdata);
        n_cmp++; if (r_wstrb !== 8'hF0) begin n_bad++; $display("FAIL sw_wstrb: got %h want f0", r_wstrb); end
        n_cmp++; if (r_wdata !== 64'hCAFE_BABE_0000_0000) begin n_bad++; $display("FAIL sw_wdata: got %h want cafebabe00000000", r_wdata); end
        n_cmp++; if (r_awaddr !== 32'h2008) begin n_bad++; $display("FAIL sw_awaddr: got %h want 00002008", r_awaddr); end
        run_access(0, 1, 3'b011, 64'h2008, 64'h1122_3344_5566_7788, 64'h0, 2'b00, 2'b11, 0);
        $display("SD DECERR: wstrb=%h wdata=%h err=%b", r_wstrb, r_wdata, r_err);
        n_cmp++; if (r_wstrb !== 8'hFF) begin n_bad++; $display("FAIL sd_wstrb: got %h want ff", r_wstrb); end
        n_cmp++; if (r_wdata !== 64'h1122_3344_5566_7788) begin n_bad++; $display("FAIL sd_wdata: got %h want 1122334455667788", r_wdata); end
        n_cmp++; if (r_err !== 1'b1) begin n_bad++; $display("FAIL sd_bresp_err: got %b want 1", r_err); end
    endtask

    task automatic test_faults();
        run_access(0, 1, 3'b010, 64'h2002, 64'h55, 64'h0, 2'b00, 2'b00, 0);
        $display("SW 0x2002 misaligned: lat=%0d mis=%b err=%b any_valid=%b", r_done_lat, r_mis, r_err, r_any_valid);
        n_cmp++; if (r_done_lat !== 1) begin n_bad++; $display("FAIL sw_mis_latency: got %0d want 1", r_done_lat); end
        n_cmp++; if ({r_mis, r_err} !== 2'b10) begin n_bad++; $display("FAIL sw_mis_flags: got %b want 10", {r_mis, r_err}); end
        n_cmp++; if (r_any_valid !== 1'b0) begin n_bad++; $display("FAIL sw_mis_no_bus: got %b want 0", r_any_valid); end
        n_cmp++; if (r_rdata !== 64'h0) begin n_bad++; $display("FAIL sw_mis_rdata: got %h want 0", r_rdata); end
        run_access(1, 0, 3'b011, 64'h1004, 64'h0, 64'h0, 2'b00, 2'b00, 0);
        $display("LD 0x1004 misaligned: lat=%0d mis=%b", r_done_lat, r_mis);
        n_cmp++; if ({r_mis, r_any_valid} !== 2'b10) begin n_bad++; $display("FAIL ld_mis: got mis/valid %b want 10", {r_mis, r_any_valid}); end
        run_access(1, 0, 3'b101, 64'h1001, 64'h0, 64'h0, 2'b00, 2'b00, 0);
        $display("LHU 0x1001 misaligned: mis=%b", r_mis);
        n_cmp++; if (r_mis !== 1'b1) begin n_bad++; $display("FAIL lhu_mis: got %b want 1", r_mis); end
        run_access(0, 0, 3'b011, 64'h1000, 64'h0, 64'h0, 2'b00, 2'b00, 0);
        $display("neither rd/wr: lat=%0d err=%b mis=%b", r_done_lat, r_err, r_mis);
        n_cmp++; if ({r_done_lat == 1, r_err, r_mis, r_any_valid} !== 4'b1100) begin
            n_bad++; $display("FAIL nokind: got lat=%0d err=%b mis=%b valid=%b want 1 1 0 0", r_done_lat, r_err, r_mis, r_any_valid);
        end
        run_access(1, 1, 3'b011, 64'h1000, 64'h0, 64'h0, 2'b00, 2'b00, 0);
        $display("both rd/wr: err=%b any_valid=%b", r_err, r_any_valid);
        n_cmp++; if ({r_err, r_any_valid} !== 2'b10) begin n_bad++; $display("FAIL bothkind: got err/valid %b want 10", {r_err, r_any_valid}); end
    endtask

    task automatic test_back_to_back();
        run_access(1, 0, 3'b011, 64'h1010, 64'h0, 64'h0123_4567_89AB_CDEF, 2'b00, 2'b00, 0);
        run_access(1, 0, 3'b000, 64'h1011, 64'h0, 64'h0000_0000_0000_7F00, 2'b00, 2'b00, 0);
        $display("back-to-back: ready_at_req=%b done_at_req=%b lat=%0d rdata=%h", r_ready_at_req, r_done_at_req, r_done_lat, r_rdata);
        n_cmp++; if ({r_ready_at_req, r_done_at_req} !== 2'b10) begin n_bad++; $display("FAIL b2b_accept: got ready/done %b want 10", {r_ready_at_req, r_done_at_req}); end
        n_cmp++; if (r_done_lat !== 3) begin n_bad++; $display("FAIL b2b_latency: got %0d want 3", r_done_lat); end
        n_cmp++; if (r_rdata !== 64'h0000_0000_0000_007F) begin n_bad++; $display("FAIL b2b_rdata: got %h want 000000000000007f", r_rdata); end
    endtask

    task automatic test_reset_midflight();
        logic saw_done = 0;
        @(negedge i_clk);
        i_req = 1; i_read = 0; i_write = 1; i_width = 3'b011; i_addr = 64'h4000; i_wdata = 64'h77;
        m_axi_awready = 1; m_axi_wready = 1; m_axi_bvalid = 0;
        @(negedge i_clk);
        i_req = 0;
        @(negedge i_clk);
        n_cmp++; if (m_axi_bready !== 1'b1) begin n_bad++; $display("FAIL midrst_in_wr_resp: got bready %b want 1", m_axi_bready); end
        i_rst = 1;
        @(negedge i_clk);
        i_rst = 0; m_axi_awready = 0;
        $display("reset in WR_RESP: ready=%b busy=%b bready=%b", o_req_ready, o_busy, m_axi_bready);
        n_cmp++; if ({m_axi_arvalid, m_axi_rready, m_axi_awvalid, m_axi_wvalid, m_axi_bready} !== 5'b0) begin
            n_bad++; $display("FAIL midrst_axi: got %b want 00000", {m_axi_arvalid, m_axi_rready, m_axi_awvalid, m_axi_wvalid, m_axi_bready});
        end
        n_cmp++; if ({o_req_ready, o_busy} !== 2'b10) begin n_bad++; $display("FAIL midrst_ready_busy: got %b want 10", {o_req_ready, o_busy}); end
        if (o_done) saw_done = 1;
        repeat (4) begin
            @(negedge i_clk);
            if (o_done) saw_done = 1;
        end
        n_cmp++; if (saw_done !== 1'b0) begin n_bad++; $display("FAIL midrst_no_done: got done pulse %b want 0", saw_done); end
    endtask

    initial begin
        test_reset();
        test_load_word();
        test_load_narrow();
        test_load_slverr();
        test_store_half_late_aw();
        test_store_lanes();
        test_faults();
        test_back_to_back();
        test_reset_midflight();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
